// File: rtl/tqvp_edge_capture.sv
// Edge-triggered timestamp capture: free-running prescaled COUNT, selectable input edge
// pushes COUNT into a small FIFO, register-mapped with a one-cycle registered read path.
module tqvp_edge_capture #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [7:0] presc;
    logic       irq_en;
    logic [1:0] mode;
    logic [2:0] sel;
    logic       en;
  } ctrl_t;

  ctrl_t          ctrl_q, ctrl_d;
  logic [31:0]    count_q;
  logic [7:0]     presc_q;
  logic           prev_q, ovf_q, tog_q;
  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [LW-1:0]  level;

  logic        wr, rd, wr_ctrl, wr_count, wr_status, rd_fifo;
  logic        empty, full, cur_bit, edge_hit, pop, push_ok, ovf_set;
  logic [31:0] wmask, ctrl_img, ctrl_new, status_img, rd_mux;
  logic [2:0]  lvl_sat;

  assign wr        = (data_write_n != 2'b11);
  assign rd        = (data_read_n != 2'b11);
  assign wr_ctrl   = wr && (address == 6'h00);
  assign wr_count  = wr && (address == 6'h04);
  assign wr_status = wr && (address == 6'h0C);
  assign rd_fifo   = rd && (address == 6'h08);

  always_comb begin
    wmask = 32'h0;
    case (data_write_n)
      2'b00:   wmask = 32'h0000_00FF;
      2'b01:   wmask = 32'h0000_FFFF;
      2'b10:   wmask = 32'hFFFF_FFFF;
      default: wmask = 32'h0;
    endcase
  end

  assign ctrl_img = {16'h0, ctrl_q.presc, 1'b0, ctrl_q.irq_en, ctrl_q.mode, ctrl_q.sel, ctrl_q.en};
  assign ctrl_new = (ctrl_img & ~wmask) | (data_in & wmask);
  assign ctrl_d   = '{presc: ctrl_new[15:8], irq_en: ctrl_new[6], mode: ctrl_new[5:4],
                      sel: ctrl_new[3:1], en: ctrl_new[0]};

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  always_comb begin
    lvl_sat = (32'(level) > 32'd7) ? 3'd7 : 3'(level);
  end
  assign status_img = {26'h0, ovf_q, full, empty, lvl_sat};

  // A CTRL write suppresses detection so a new SEL/MODE never sees stale history
  assign cur_bit = ui_in[ctrl_q.sel];
  always_comb begin
    edge_hit = 1'b0;
    case (ctrl_q.mode)
      2'b00:   edge_hit = cur_bit & ~prev_q;
      2'b01:   edge_hit = ~cur_bit & prev_q;
      2'b10:   edge_hit = cur_bit ^ prev_q;
      default: edge_hit = 1'b0;
    endcase
    edge_hit = edge_hit & ctrl_q.en & ~wr_ctrl;
  end

  assign pop     = rd_fifo && !empty;
  assign push_ok = edge_hit && (!full || pop);
  assign ovf_set = edge_hit && full && !pop;

  always_comb begin
    rd_mux = 32'h0;
    case (address)
      6'h00:   rd_mux = ctrl_img;
      6'h04:   rd_mux = count_q;
      6'h08:   rd_mux = empty ? 32'h0 : mem[rd_ptr];
      6'h0C:   rd_mux = status_img;
      default: rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      prev_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= ctrl_d;
        prev_q <= ui_in[ctrl_d.sel];
      end else begin
        prev_q <= cur_bit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      presc_q <= '0;
    end else if (wr_count) begin
      count_q <= (count_q & ~wmask) | (data_in & wmask);
      presc_q <= '0;
    end else if (!ctrl_q.en) begin
      presc_q <= '0;
    end else if (presc_q >= ctrl_q.presc) begin
      presc_q <= '0;
      count_q <= count_q + 32'd1;
    end else begin
      presc_q <= presc_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      ovf_q  <= 1'b0;
      tog_q  <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      tog_q <= tog_q ^ push_ok;
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // A fresh overflow wins over a same-cycle clear
      if (ovf_set)                      ovf_q <= 1'b1;
      else if (wr_status && data_in[5]) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_ready     <= 1'b0;
      data_out       <= '0;
      user_interrupt <= 1'b0;
    end else begin
      data_ready     <= rd;
      data_out       <= rd ? rd_mux : 32'h0;
      user_interrupt <= ctrl_q.irq_en & (~empty | ovf_q);
    end
  end

  assign uo_out = {5'b0, ovf_q, ~empty, tog_q};

endmodule
